// File: rtl/seq_addsub_nb_if.sv
// seq_addsub_nb_if: start/ready/done operand and result bundle for seq_addsub_nb
interface seq_addsub_nb_if #(parameter int WIDTH = 16);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic             Cin;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             Zero;
  logic             done;
  modport master (output start, A, B, Sub, Cin, input ready, Sum, Cout, Ovf, Zero, done);
  modport slave (input start, A, B, Sub, Cin, output ready, Sum, Cout, Ovf, Zero, done);
endinterface

// File: rtl/seq_addsub_nb.sv
// seq_addsub_nb: multicycle add/sub processing DIGIT bits per cycle, LSB slice first
module seq_addsub_nb #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic          clk,
  input logic          rst,
  seq_addsub_nb_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_cfg
    $error("seq_addsub_nb: DIGIT must divide WIDTH");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_r, bx_r, sum_r, sum_n;
  logic [CW-1:0]    cnt;
  logic             carry, cout_r, ovf_r, zero_r;
  logic [DIGIT-1:0] a_s, b_s, s;
  logic             c_s, last, accept;
  int               off;
  assign accept = state == IDLE && bus.start;
  assign last = int'(cnt) == NDIG - 1;
  // Slices are extracted by shifting so the index width never depends on the counter width
  always_comb begin
    off = int'(cnt) * DIGIT;
    a_s = DIGIT'(a_r >> off);
    b_s = DIGIT'(bx_r >> off);
    {c_s, s} = {1'b0, a_s} + {1'b0, b_s} + (DIGIT + 1)'(carry);
    sum_n = (sum_r & ~(WIDTH'({DIGIT{1'b1}}) << off)) | (WIDTH'(s) << off);
  end
  always_comb begin
    state_n = accept ? RUN : (state == RUN && last) ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_r   <= bus.A;
        bx_r  <= bus.Sub ? ~bus.B : bus.B;
        carry <= bus.Cin ^ bus.Sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        sum_r <= sum_n;
        carry <= c_s;
        cnt   <= cnt + 1'b1;
        if (last) begin
          cout_r <= c_s;
          ovf_r  <= (a_r[WIDTH-1] == bx_r[WIDTH-1]) && (s[DIGIT-1] != a_r[WIDTH-1]);
          zero_r <= sum_n == '0;
        end
      end
    end
  end
  assign bus.ready = state == IDLE;
  assign bus.done  = state == DONE;
  assign bus.Sum   = sum_r;
  assign bus.Cout  = cout_r;
  assign bus.Ovf   = ovf_r;
  assign bus.Zero  = zero_r;
endmodule
